ysyx_22050039_fetch_unit: RTL and testbench

YSYX_22050039_FETCH_UNIT -- requirements
Module: ysyx_22050039_fetch_unit

---
 rtl/ysyx_22050039_pkg.sv | 13 +
 rtl/ysyx_22050039_fifo.sv | 60 ++++++
 rtl/ysyx_22050039_fetch_unit.sv | 130 +++++++++++++
 tb/tb_ysyx_22050039_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050039_pkg.sv
// Shared constants for the instruction fetch unit: default reset PC,
// instruction width and control FSM state encoding.
package ysyx_22050039_pkg;

  localparam int unsigned ILEN_DEFAULT     = 32;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] S_REQ  = 2'd1;
  localparam logic [STATE_W-1:0] S_WAIT = 2'd2;

endpackage

// File: rtl/ysyx_22050039_fifo.sv
// Register-based fetch queue; simultaneous push and pop are honoured even
// when full, and flush empties it at the next edge.
module ysyx_22050039_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = r_mem[r_rptr];
  assign w_pop    = pop && !empty;
  assign w_push   = push && (!full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= push_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_22050039_fetch_unit.sv
// Instruction fetch unit: one outstanding memory request at a time, queue
// slots reserved at request time, stale responses dropped after a redirect.
module ysyx_22050039_fetch_unit
  import ysyx_22050039_pkg::*;
#(
  parameter int unsigned    XLEN     = 64,
  parameter int unsigned    ILEN     = ILEN_DEFAULT,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            imem_rerr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_inst,
  output logic            out_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = XLEN + ILEN + 1;

  logic [STATE_W-1:0] r_state, w_state_next;
  logic [XLEN-1:0]    r_fetch_pc, w_fetch_pc_next;
  logic [XLEN-1:0]    r_wait_pc, w_wait_pc_next;
  logic [XLEN-1:0]    r_redir_pc, w_redir_pc_next;
  logic               r_drop, w_drop_next;
  logic               r_pend, w_pend_next;
  logic [XLEN-1:0]    w_redir_aligned;
  logic [ILEN-1:0]    w_inst;
  logic               w_push, w_pop, w_full, w_empty, w_slot_free;
  logic [CW-1:0]      w_count, w_count_next;
  logic [EW-1:0]      w_head;

  assign w_redir_aligned = redirect_pc & ~XLEN'(3);
  assign w_inst          = imem_rerr ? '0 : imem_rdata;
  assign out_valid       = !w_empty && !redirect;
  assign w_pop           = out_valid && out_ready;
  assign w_push          = (r_state == S_WAIT) && imem_rvalid && !r_drop && !redirect
                           && (!w_full || w_pop);
  assign w_count_next    = redirect ? '0 : w_count + CW'(w_push) - CW'(w_pop);
  assign w_slot_free     = (w_count_next < CW'(DEPTH));
  assign imem_req        = (r_state == S_REQ);
  assign imem_addr       = r_fetch_pc;
  assign {out_pc, out_inst, out_err} = w_head;

  ysyx_22050039_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data ({r_wait_pc, w_inst, imem_rerr}),
    .pop       (w_pop),
    .flush     (redirect),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // A redirect seen while a request is still ungranted is parked in r_pend
  // so the bus address stays stable; it is applied at that request's grant.
  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_wait_pc_next  = r_wait_pc;
    w_redir_pc_next = r_redir_pc;
    w_drop_next     = r_drop;
    w_pend_next     = r_pend;
    case (r_state)
      S_IDLE: if (w_slot_free) w_state_next = S_REQ;
      S_REQ: begin
        if (imem_gnt) begin
          w_state_next    = S_WAIT;
          w_wait_pc_next  = r_fetch_pc;
          w_drop_next     = redirect || r_pend;
          w_fetch_pc_next = r_pend ? r_redir_pc : r_fetch_pc + XLEN'(4);
          w_pend_next     = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_drop_next  = 1'b0;
          w_state_next = w_slot_free ? S_REQ : S_IDLE;
        end else if (redirect) begin
          w_drop_next  = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (redirect) begin
      if ((r_state == S_REQ) && !imem_gnt) begin
        w_pend_next     = 1'b1;
        w_redir_pc_next = w_redir_aligned;
      end else begin
        w_fetch_pc_next = w_redir_aligned;
        w_pend_next     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_wait_pc  <= '0;
      r_redir_pc <= '0;
      r_drop     <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_wait_pc  <= w_wait_pc_next;
      r_redir_pc <= w_redir_pc_next;
      r_drop     <= w_drop_next;
      r_pend     <= w_pend_next;
    end
  end

endmodule

// File: tb/tb_ysyx_22050039_fetch_unit.sv
// Scoreboard bench for the fetch unit: directed scenarios push hand-computed
// expected entries; a monitor pops and compares on every accepted head.
module tb_ysyx_22050039_fetch_unit;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic        clk, rst_n, redirect, imem_req, imem_gnt, imem_rvalid, imem_rerr;
  logic        out_valid, out_ready, out_err;
  logic [63:0] redirect_pc, imem_addr, out_pc;
  logic [31:0] imem_rdata, out_inst;

  int checks = 0;
  int failures = 0;

  exp_t        sb[$];
  logic [63:0] grant_log[$];

  // memory model controls
  int          budget = 0;
  int          gnt_block = 0;
  int          rv_delay = 0;
  int          n_grants = 0;
  logic [63:0] err_addr = '1;
  logic        late_rv = 1'b0;

  ysyx_22050039_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .imem_rerr   (imem_rerr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_err     (out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void expect_entry(input logic [63:0] pc, input logic [31:0] inst,
                                       input logic err);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    e.err = err;
    sb.push_back(e);
  endfunction

  // Memory: acts at negedge; handshakes are judged from what was driven last negedge.
  initial begin
    logic        req_s, gnt_s, had_out;
    logic [63:0] addr_s, o_addr;
    int          o_cnt;
    req_s = 0; gnt_s = 0; had_out = 0; addr_s = '0; o_addr = '0; o_cnt = 0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0; imem_rerr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        had_out = 0; req_s = 0; gnt_s = 0;
        imem_gnt = 0; imem_rvalid = late_rv; imem_rdata = 32'hDEAD_BEEF; imem_rerr = 0;
      end else begin
        if (imem_rvalid) had_out = 0;
        if (req_s && gnt_s) begin
          had_out = 1; o_addr = addr_s; o_cnt = rv_delay;
          n_grants++; budget--; grant_log.push_back(addr_s);
        end
        imem_rvalid = 0; imem_rerr = 0; imem_rdata = '0;
        if (had_out) begin
          if (o_cnt == 0) begin
            imem_rvalid = 1;
            imem_rerr   = (o_addr == err_addr);
            imem_rdata  = imem_rerr ? 32'hBAD0_BAD0 : {o_addr[15:0], 16'h0013};
          end else begin
            o_cnt--;
          end
        end
        if (imem_req && gnt_block > 0) begin
          gnt_block--;
          imem_gnt = 0;
        end else begin
          imem_gnt = imem_req && (budget > 0);
        end
        req_s = imem_req; addr_s = imem_addr; gnt_s = imem_gnt;
      end
    end
  end

  // Monitor: a pop happens at the next posedge when valid && ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected: got pc=%h inst=%h err=%b expected no entry",
                   out_pc, out_inst, out_err);
        end else begin
          e = sb.pop_front();
          if (out_pc !== e.pc || out_inst !== e.inst || out_err !== e.err) begin
            failures++;
            $display("FAIL pop: got pc=%h inst=%h err=%b expected pc=%h inst=%h err=%b",
                     out_pc, out_inst, out_err, e.pc, e.inst, e.err);
          end
        end
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk); #1;
    rst_n = 0; redirect = 0; redirect_pc = '0; out_ready = 0;
    budget = 0; gnt_block = 0; rv_delay = 0; err_addr = '1; late_rv = 0;
    repeat (3) @(negedge clk);
    #1;
    sb.delete(); grant_log.delete(); n_grants = 0;
    rst_n = 1;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((sb.size() != 0 || budget != 0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    #1;
    check({name, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_grant(input string name);
    for (int c = 0; c < 20 && n_grants == 0; c++) begin
      @(negedge clk); #1;
    end
    check({name, "_grant_seen"}, 64'(n_grants), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 0; redirect = 0; redirect_pc = '0; out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_imem_req", 64'(imem_req), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_inst", 64'(out_inst), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    rst_n = 1;
    @(negedge clk); #1;
    check("rel_imem_req", 64'(imem_req), 64'd1);
    check("rel_imem_addr", imem_addr, 64'h8000_0000);

    // Zero-wait streaming from reset
    reset_dut();
    out_ready = 1; budget = 3;
    expect_entry(64'h8000_0000, 32'h0000_0013, 1'b0);
    expect_entry(64'h8000_0004, 32'h0004_0013, 1'b0);
    expect_entry(64'h8000_0008, 32'h0008_0013, 1'b0);
    wait_drain("stream");
    check("stream_next_req", 64'(imem_req), 64'd1);
    check("stream_next_addr", imem_addr, 64'h8000_000C);

    // Backpressure: only DEPTH grants, then resume at 0x80000010
    reset_dut();
    budget = 8;
    for (int i = 0; i < 8; i++) begin
      logic [63:0] a;
      a = 64'h8000_0000 + 64'(4 * i);
      expect_entry(a, {a[15:0], 16'h0013}, 1'b0);
    end
    repeat (20) @(negedge clk);
    #1;
    check("full_grants", 64'(n_grants), 64'd4);
    check("full_req_low", 64'(imem_req), 64'd0);
    check("full_head_pc", out_pc, 64'h8000_0000);
    out_ready = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (imem_req) break;
    end
    check("resume_req", 64'(imem_req), 64'd1);
    check("resume_addr", imem_addr, 64'h8000_0010);
    wait_drain("full");

    // Redirect while waiting for a response
    reset_dut();
    out_ready = 1; rv_delay = 3; budget = 2;
    expect_entry(64'h8000_1000, 32'h1000_0013, 1'b0);
    wait_grant("wait_redir");
    redirect = 1; redirect_pc = 64'h8000_1002;
    @(negedge clk); #1;
    redirect = 0;
    wait_drain("wait_redir");
    check("wait_redir_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() >= 2) check("wait_redir_addr", grant_log[1], 64'h8000_1000);
    check("wait_redir_next", imem_addr, 64'h8000_1004);

    // Redirects while the request is held ungranted; the last one wins
    reset_dut();
    out_ready = 1; gnt_block = 5; budget = 2;
    expect_entry(64'h8000_2000, 32'h2000_0013, 1'b0);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      redirect    = (c == 1) || (c == 2);
      redirect_pc = (c == 1) ? 64'h8000_3000 : 64'h8000_2000;
      if (n_grants == 0) check("hold_addr", imem_req ? imem_addr : 64'hX, 64'h8000_0000);
    end
    redirect = 0;
    wait_drain("hold_redir");
    check("hold_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() >= 2) begin
      check("hold_stale_addr", grant_log[0], 64'h8000_0000);
      check("hold_new_addr", grant_log[1], 64'h8000_2000);
    end

    // Access fault on the second fetch
    reset_dut();
    out_ready = 1; budget = 3; err_addr = 64'h8000_0004;
    expect_entry(64'h8000_0000, 32'h0000_0013, 1'b0);
    expect_entry(64'h8000_0004, 32'h0000_0000, 1'b1);
    expect_entry(64'h8000_0008, 32'h0008_0013, 1'b0);
    wait_drain("rerr");

    // Reset in WAIT with a response arriving during reset
    reset_dut();
    out_ready = 1; rv_delay = 5; budget = 1;
    wait_grant("mid_rst");
    rst_n = 0; late_rv = 1;
    repeat (3) begin
      @(negedge clk); #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
    end
    late_rv = 0;
    @(negedge clk); #1;
    budget = 1;
    expect_entry(64'h8000_0000, 32'h0000_0013, 1'b0);
    rst_n = 1;
    wait_drain("mid_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
